// File: rtl/i2c_txn_scheduler.sv
// Arbitrates the i2c_master between a host command port and a periodic temperature poll.
// It runs one fixed-length transaction at a time and captures read data when the transaction ends.
module i2c_txn_scheduler #(
    parameter int unsigned POLL_PERIOD = 1000,
    parameter int unsigned XFER_CYCLES = 200,
    parameter logic [2:0]  SENSOR_ADR  = 3'b101
) (
    input  logic       CLK,
    input  logic       RES,
    input  logic       host_req,
    input  logic       host_rw,
    input  logic [2:0] host_adr,
    input  logic [7:0] host_wdata,
    output logic       host_ack,
    output logic       host_done,
    output logic [7:0] host_rdata,
    input  logic       poll_en,
    output logic [7:0] temp_val,
    output logic       temp_valid,
    output logic       m_start,
    output logic       m_rw,
    output logic [2:0] m_adr,
    output logic [7:0] m_wdata,
    input  logic [7:0] m_rdata,
    output logic       busy
);

    localparam int unsigned PCW = $clog2(POLL_PERIOD);
    localparam int unsigned XCW = (XFER_CYCLES > 1) ? $clog2(XFER_CYCLES) : 1;
    localparam logic [PCW-1:0] POLL_RELOAD = PCW'(POLL_PERIOD - 1);
    localparam logic [XCW-1:0] XFER_RELOAD = XCW'(XFER_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, CAPTURE} state_t;
    typedef enum logic {SRC_HOST, SRC_POLL} src_t;

    state_t         state, state_n;
    src_t           last_grant, last_grant_n;
    logic [XCW-1:0] wait_cnt, wait_cnt_n;
    logic [PCW-1:0] poll_cnt, poll_cnt_n;
    logic           poll_pending, poll_pending_n;
    logic           poll_grant;
    logic           poll_expire;

    logic       host_ack_n, host_done_n, temp_valid_n, m_start_n, busy_n, m_rw_n;
    logic [2:0] m_adr_n;
    logic [7:0] m_wdata_n, host_rdata_n, temp_val_n;

    // Poll timer; a same-cycle expiry outranks the clear from a poll grant
    always_comb begin
        poll_expire    = poll_en && (poll_cnt == '0);
        poll_cnt_n     = poll_cnt - PCW'(1);
        poll_pending_n = poll_pending;
        if (!poll_en) begin
            poll_cnt_n     = POLL_RELOAD;
            poll_pending_n = 1'b0;
        end else if (poll_expire) begin
            poll_cnt_n     = POLL_RELOAD;
            poll_pending_n = 1'b1;
        end else if (poll_grant) begin
            poll_pending_n = 1'b0;
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_n      = state;
        last_grant_n = last_grant;
        wait_cnt_n   = wait_cnt;
        poll_grant   = 1'b0;
        host_ack_n   = 1'b0;
        host_done_n  = 1'b0;
        temp_valid_n = 1'b0;
        m_start_n    = 1'b0;
        m_rw_n       = m_rw;
        m_adr_n      = m_adr;
        m_wdata_n    = m_wdata;
        host_rdata_n = host_rdata;
        temp_val_n   = temp_val;

        case (state)
            IDLE: begin
                if (host_req && (!poll_pending || last_grant == SRC_POLL)) begin
                    m_rw_n       = host_rw;
                    m_adr_n      = host_adr;
                    m_wdata_n    = host_wdata;
                    last_grant_n = SRC_HOST;
                    host_ack_n   = 1'b1;
                    m_start_n    = 1'b1;
                    state_n      = ISSUE;
                end else if (poll_pending) begin
                    m_rw_n       = 1'b1;
                    m_adr_n      = SENSOR_ADR;
                    m_wdata_n    = 8'h00;
                    last_grant_n = SRC_POLL;
                    poll_grant   = 1'b1;
                    m_start_n    = 1'b1;
                    state_n      = ISSUE;
                end
            end
            ISSUE: begin
                wait_cnt_n = XFER_RELOAD;
                state_n    = WAIT;
            end
            WAIT: begin
                if (wait_cnt == '0) begin
                    // Done/valid and captured data become visible together in CAPTURE
                    state_n = CAPTURE;
                    if (last_grant == SRC_HOST) begin
                        host_done_n = 1'b1;
                        if (m_rw) host_rdata_n = m_rdata;
                    end else begin
                        temp_valid_n = 1'b1;
                        temp_val_n   = m_rdata;
                    end
                end else begin
                    wait_cnt_n = wait_cnt - XCW'(1);
                end
            end
            CAPTURE: state_n = IDLE;
            default: state_n = IDLE;
        endcase

        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge CLK or posedge RES) begin
        if (RES) begin
            state        <= IDLE;
            last_grant   <= SRC_POLL;
            wait_cnt     <= '0;
            poll_cnt     <= POLL_RELOAD;
            poll_pending <= 1'b0;
            host_ack     <= 1'b0;
            host_done    <= 1'b0;
            host_rdata   <= 8'h00;
            temp_val     <= 8'h00;
            temp_valid   <= 1'b0;
            m_start      <= 1'b0;
            m_rw         <= 1'b0;
            m_adr        <= 3'b000;
            m_wdata      <= 8'h00;
            busy         <= 1'b0;
        end else begin
            state        <= state_n;
            last_grant   <= last_grant_n;
            wait_cnt     <= wait_cnt_n;
            poll_cnt     <= poll_cnt_n;
            poll_pending <= poll_pending_n;
            host_ack     <= host_ack_n;
            host_done    <= host_done_n;
            host_rdata   <= host_rdata_n;
            temp_val     <= temp_val_n;
            temp_valid   <= temp_valid_n;
            m_start      <= m_start_n;
            m_rw         <= m_rw_n;
            m_adr        <= m_adr_n;
            m_wdata      <= m_wdata_n;
            busy         <= busy_n;
        end
    end

endmodule

// File: doc/i2c_txn_scheduler.md
Name: i2c_txn_scheduler

Overview:
- Sequences the i2c_master and shares it between two requesters: a host command port and an internal periodic temperature poll.
- Issues exactly one transaction at a time and drives the master's start, rw, adr and write-data inputs.
- The master has no completion output, so transaction end is a fixed cycle count after start. Read data is captured from the master's read-data output at that point.
- Sits between the top-level control logic and i2c_master.

Parameters:
- POLL_PERIOD, 1000, CLK cycles between automatic temperature polls (min 2).
- XFER_CYCLES, 200, CLK cycles from the start pulse to valid read data / bus free (min 1).
- SENSOR_ADR, 3'b101, device address used for automatic polls.

Ports:
- CLK  in  1  system clock; all logic on rising edge.
- RES  in  1  asynchronous, active-high reset.
- host_req  in  1  level request; held until host_ack.
- host_rw  in  1  1 = read, 0 = write; sampled on grant.
- host_adr  in  3  device address; sampled on grant.
- host_wdata  in  8  write byte; sampled on grant.
- host_ack  out  1  one-cycle pulse; request accepted, fields captured.
- host_done  out  1  one-cycle pulse; host transaction complete.
- host_rdata  out  8  last host read byte; holds until the next host read completes.
- poll_en  in  1  enables the periodic poll.
- temp_val  out  8  last polled temperature byte.
- temp_valid  out  1  one-cycle pulse when temp_val updates.
- m_start  out  1  to master start; one-cycle pulse.
- m_rw  out  1  to master rw.
- m_adr  out  3  to master adr.
- m_wdata  out  8  to master temp_reg_d1.
- m_rdata  in  8  from master temp_input.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset value of every output: all outputs 0. Internal poll counter loads POLL_PERIOD-1; poll_pending=0; last_grant=POLL, so the host wins the first tie.
- Poll timer:
  - While poll_en=1, the counter decrements each cycle. At 0 it sets poll_pending and reloads POLL_PERIOD-1.
  - poll_pending is sticky until granted. Expiries while pending are coalesced; there is never more than one pending poll.
  - poll_en=0: counter held at POLL_PERIOD-1 and poll_pending cleared.
- States: IDLE, ISSUE, WAIT, CAPTURE.
- IDLE:
  - With no request, stay in IDLE.
  - With only one request, grant it.
  - With host_req and poll_pending in the same cycle: grant the source that is not last_grant (round robin).
  - On grant: latch rw/adr/wdata into m_rw/m_adr/m_wdata. A poll uses rw=1, adr=SENSOR_ADR, wdata=8'h00.
  - On grant: update last_grant and go to ISSUE.
  - On a poll grant: clear poll_pending.
- ISSUE (1 cycle): m_start=1. host_ack=1 if the grant went to the host. Load the wait counter with XFER_CYCLES-1. Go to WAIT.
- WAIT: m_start=0. Decrement the wait counter. At 0, go to CAPTURE. m_rw/m_adr/m_wdata are held stable from ISSUE through CAPTURE.
- CAPTURE (1 cycle):
  - If rw=1: latch m_rdata into host_rdata (host grant) or temp_val (poll grant).
  - Pulse host_done (host grant, read or write) or temp_valid (poll grant, always a read).
  - Go to IDLE.
- Latency: host_req high in IDLE at cycle t, no contention:
  - host_ack and m_start at t+1.
  - WAIT for cycles t+2 .. t+1+XFER_CYCLES.
  - host_done at t+2+XFER_CYCLES.
  - Earliest next grant decision at t+3+XFER_CYCLES.
- host_req deasserted before ack: the request is ignored if no grant has occurred. Fields are only sampled on the grant cycle.
- Requests arriving while busy are not granted. host_req must stay high; the poll stays pending.
- Timer runs independently of state.
- Reset asserted mid-transaction: everything returns to reset values immediately (async). No done/valid pulse is emitted. m_start drops at once.
- Timer expiry in the same cycle as a poll grant: pending is re-set for the next poll (expiry wins over clear).

Test Plan (POLL_PERIOD=20, XFER_CYCLES=8):
1. RES pulse mid-WAIT of a host read → all outputs 0 immediately; no host_done; after release, first poll pending 20 cycles later.
2. poll_en=0, host_req with rw=1, adr=3'b101 at cycle t, m_rdata=8'h5A → host_ack and m_start at t+1 with m_adr=101, m_rw=1; host_done at t+10; host_rdata=8'h5A.
3. Host write rw=0, adr=3'b010, wdata=8'hC3 → m_wdata=C3 and m_rw=0 held t+1..t+10; host_done pulses; host_rdata unchanged.
4. poll_en=1, no host traffic, m_rdata=8'h01:
   - temp_valid pulses every 20 cycles with temp_val=01 and m_adr=101.
   - start-to-start spacing is 20 cycles.
5. host_req and poll_pending coincide after reset → host granted first. The poll is granted in the first IDLE decision after host_done. On the next coincidence the host wins again, since last_grant=POLL.
6. host_req held continuously with poll_en=1 → grants alternate host/poll whenever both are pending; the poll is never starved; only one m_start per transaction.
